config_sequencer: RTL and testbench
===================================

# config_sequencer

Sequences the clock display's configuration mode. It converts debounced push-button levels into three things: the mode code, the cursor position and the blink signal that the character generator uses to draw the editing cursor. It also issues one-cycle increment/decrement strobes to the time, date and timer registers for the field under the cursor. It sits between the button debouncers and the RTC register file / character generator.

## Interface

Parameters:
- BLINK_CYCLES, 25_000_000: clk cycles per blink half-period (0.5 s at 50 MHz).
- IDLE_HALVES, 20: number of blink half-periods without a key press before auto-exit to normal mode.

Ports:
- clk  in  1  system clock; everything is synchronous to its rising edge.
- reset  in  1  synchronous, active-high reset.
- btn_config  in  1  debounced level; a press cycles the mode.
- btn_left  in  1  debounced level; moves the cursor one field left.
- btn_right  in  1  debounced level; moves the cursor one field right.
- btn_up  in  1  debounced level; requests an increment of the field under the cursor.
- btn_down  in  1  debounced level; requests a decrement of the field under the cursor.
- config_mode  out  3  mode code: 0 normal, 1 time, 2 date, 4 timer.
- cursor_location  out  2  field position: 2 leftmost pair, 1 middle pair, 0 rightmost pair, 3 weekday (date mode only).
- parpadeo  out  1  blink phase; 1 means the cursor is drawn.
- inc_pulse  out  1  one-cycle increment strobe for the selected field.
- dec_pulse  out  1  one-cycle decrement strobe for the selected field.

## Operation

- Each button is registered once. A press is a rising edge: current sample is 1 and previous sample is 0.
- At most one press is acted on per cycle. Priority: config > left > right > up > down. Lower-priority edges in the same cycle are discarded, not queued.
- Mode FSM states are NORMAL, HORA, FECHA, TIMER.
  - A config press advances NORMAL→HORA→FECHA→TIMER→NORMAL.
  - Output codes are 0, 1, 2, 4 respectively.
- Entering HORA, FECHA or TIMER sets cursor_location to 2. Entering NORMAL sets it to 0.
- Cursor range: max is 2 in HORA and TIMER, 3 in FECHA.
  - Left press: cursor+1; from max it wraps to 0.
  - Right press: cursor-1; from 0 it wraps to max.
- In NORMAL:
  - left, right, up and down are ignored.
  - parpadeo is held at 0.
  - inc_pulse and dec_pulse are never asserted.
- In an edit mode, up raises inc_pulse and down raises dec_pulse, each for exactly one cycle. Consumers decode the target field from the config_mode and cursor_location values present in that same cycle.
- Blink counter: counts 0..BLINK_CYCLES-1 in edit modes. At terminal count it wraps to 0 and toggles parpadeo.
- Any accepted press in an edit mode clears the blink counter and sets parpadeo=1, so the cursor is visible immediately.
- Idle counter:
  - Increments on each blink toggle.
  - Clears on any accepted press.
  - On reaching IDLE_HALVES, the FSM goes to NORMAL on the next cycle, with the same effects as a config press from TIMER.
- Width rules:
  - Blink counter width is $clog2(BLINK_CYCLES).
  - Idle counter width is $clog2(IDLE_HALVES+1).
  - Counters saturate or wrap only as stated above, never silently.

## Timing

- Reset values: config_mode=0, cursor_location=0, parpadeo=0, inc_pulse=0, dec_pulse=0. The previous-sample registers reset to 1, so a button already held through reset does not produce a press.
- Latency: a button level first seen high in cycle n produces its output change (mode, cursor or pulse) registered at the edge ending cycle n+1. All outputs are registered.
- A held button produces exactly one action; release followed by a re-press is required for another.
- A config press in the same cycle as the idle timeout acts as one config press, never two transitions.
- Reset asserted mid-edit takes effect at the next edge. Any pulse in flight is dropped.
- parpadeo toggles exactly BLINK_CYCLES cycles after the last toggle or press-restart.

## Structure

- Shared package config_pkg:
  - Mode codes MODE_NORMAL=3'd0, MODE_HORA=3'd1, MODE_FECHA=3'd2, MODE_TIMER=3'd4.
  - Cursor maxima CUR_MAX_HHMMSS=2'd2, CUR_MAX_FECHA=2'd3.
  - These constants are also used by the character generator and the RTC register file.
- Sub-module button_edge_detect:
  - Parameter N=5.
  - Registers the N button levels and outputs N one-cycle rising-edge strobes.
  - Previous-sample registers reset to all-ones.
- The FSM, cursor logic, blink counter and idle counter live in config_sequencer.

## Test plan

- Reset with btn_config held high, then release and press once → no action while held; after the re-press, config_mode=1 and cursor_location=2 one cycle after the edge.
- In HORA, press left 3 times → cursor_location 2→0→1→2. In FECHA, press right from 0 → cursor_location=3.
- In TIMER at cursor 1, btn_up and btn_left rise in the same cycle → cursor_location=2, no inc_pulse. A lone btn_down held 100 cycles → exactly one dec_pulse, 1 cycle wide.
- With BLINK_CYCLES=4, enter HORA → parpadeo toggles every 4 cycles. A press mid-period forces parpadeo=1 and the next toggle comes 4 cycles later.
- With BLINK_CYCLES=4 and IDLE_HALVES=3, enter FECHA and wait → after 3 toggles, config_mode=0, cursor_location=0, parpadeo=0.
- Assert reset during FECHA while btn_up is rising → all outputs return to reset values and no inc_pulse appears.

Source files
------------

// File: rtl/config_pkg.sv
// Shared configuration-mode constants and types for the sequencer, character generator
// and RTC register file.
package config_pkg;

  localparam logic [2:0] MODE_NORMAL = 3'd0;
  localparam logic [2:0] MODE_HORA   = 3'd1;
  localparam logic [2:0] MODE_FECHA  = 3'd2;
  localparam logic [2:0] MODE_TIMER  = 3'd4;

  localparam logic [1:0] CUR_MAX_HHMMSS = 2'd2;
  localparam logic [1:0] CUR_MAX_FECHA  = 2'd3;

  // Bit positions in the packed button vector.
  localparam int unsigned NUM_BTN    = 5;
  localparam int unsigned BTN_CONFIG = 4;
  localparam int unsigned BTN_LEFT   = 3;
  localparam int unsigned BTN_RIGHT  = 2;
  localparam int unsigned BTN_UP     = 1;
  localparam int unsigned BTN_DOWN   = 0;

  typedef enum logic [1:0] {StNormal, StHora, StFecha, StTimer} mode_state_e;

  typedef enum logic [2:0] {
    PressNone, PressConfig, PressLeft, PressRight, PressUp, PressDown
  } press_e;

  function automatic logic [2:0] mode_code(mode_state_e st);
    logic [2:0] code;
    unique case (st)
      StNormal: code = MODE_NORMAL;
      StHora:   code = MODE_HORA;
      StFecha:  code = MODE_FECHA;
      StTimer:  code = MODE_TIMER;
      default:  code = MODE_NORMAL;
    endcase
    return code;
  endfunction

  function automatic logic [1:0] cursor_max(mode_state_e st);
    return (st == StFecha) ? CUR_MAX_FECHA : CUR_MAX_HHMMSS;
  endfunction

endpackage

// File: rtl/config_sequencer_if.sv
// Button levels in, mode/cursor/blink/strobe outputs back out.
interface config_sequencer_if;
  logic       btn_config;
  logic       btn_left;
  logic       btn_right;
  logic       btn_up;
  logic       btn_down;
  logic [2:0] config_mode;
  logic [1:0] cursor_location;
  logic       parpadeo;
  logic       inc_pulse;
  logic       dec_pulse;

  modport master (
    output btn_config, btn_left, btn_right, btn_up, btn_down,
    input  config_mode, cursor_location, parpadeo, inc_pulse, dec_pulse
  );

  modport slave (
    input  btn_config, btn_left, btn_right, btn_up, btn_down,
    output config_mode, cursor_location, parpadeo, inc_pulse, dec_pulse
  );
endinterface

// File: rtl/button_edge_detect.sv
// Registers N debounced button levels and emits registered one-cycle rising-edge strobes.
module button_edge_detect #(
  parameter int unsigned N = 5
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] level,
  output logic [N-1:0] rise
);

  logic [N-1:0] prev_q;
  logic [N-1:0] rise_q;

  // prev resets high so a button held through reset never looks like a press.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_q <= '1;
      rise_q <= '0;
    end else begin
      prev_q <= level;
      rise_q <= level & ~prev_q;
    end
  end

  assign rise = rise_q;

endmodule

// File: rtl/config_sequencer.sv
// Configuration-mode sequencer: mode FSM, cursor, blink phase, idle auto-exit and
// increment/decrement strobes for the field under the cursor.
module config_sequencer
  import config_pkg::*;
#(
  parameter int unsigned BLINK_CYCLES = 25_000_000,
  parameter int unsigned IDLE_HALVES  = 20
) (
  input logic               clk,
  input logic               reset,
  config_sequencer_if.slave cfg
);

  localparam int unsigned BLINK_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  localparam int unsigned IDLE_W  = (IDLE_HALVES > 0) ? $clog2(IDLE_HALVES + 1) : 1;
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_CYCLES - 1);
  localparam logic [IDLE_W-1:0]  IDLE_LAST  = IDLE_W'(IDLE_HALVES);

  logic [NUM_BTN-1:0] rise;
  mode_state_e        state_q, state_d;
  press_e             press;
  logic               timeout;

  logic [2:0]         mode_q, mode_d;
  logic [1:0]         cursor_q, cursor_d;
  logic [BLINK_W-1:0] blink_q, blink_d;
  logic [IDLE_W-1:0]  idle_q, idle_d;
  logic               parpadeo_q, parpadeo_d;
  logic               inc_q, inc_d;
  logic               dec_q, dec_d;

  button_edge_detect #(
    .N(NUM_BTN)
  ) u_edge (
    .clk  (clk),
    .reset(reset),
    .level({cfg.btn_config, cfg.btn_left, cfg.btn_right, cfg.btn_up, cfg.btn_down}),
    .rise (rise)
  );

  // One accepted press per cycle; in normal mode only config counts.
  always_comb begin
    press = PressNone;
    if (rise[BTN_CONFIG]) begin
      press = PressConfig;
    end else if (state_q != StNormal) begin
      if (rise[BTN_LEFT])       press = PressLeft;
      else if (rise[BTN_RIGHT]) press = PressRight;
      else if (rise[BTN_UP])    press = PressUp;
      else if (rise[BTN_DOWN])  press = PressDown;
    end
  end

  assign timeout = (state_q != StNormal) && (idle_q == IDLE_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StNormal;
      mode_q     <= MODE_NORMAL;
      cursor_q   <= '0;
      blink_q    <= '0;
      idle_q     <= '0;
      parpadeo_q <= 1'b0;
      inc_q      <= 1'b0;
      dec_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      cursor_q   <= cursor_d;
      blink_q    <= blink_d;
      idle_q     <= idle_d;
      parpadeo_q <= parpadeo_d;
      inc_q      <= inc_d;
      dec_q      <= dec_d;
    end
  end

  // A config press coinciding with timeout is a single config step.
  always_comb begin
    state_d = state_q;
    if (press == PressConfig) begin
      unique case (state_q)
        StNormal: state_d = StHora;
        StHora:   state_d = StFecha;
        StFecha:  state_d = StTimer;
        StTimer:  state_d = StNormal;
        default:  state_d = StNormal;
      endcase
    end else if (timeout) begin
      state_d = StNormal;
    end
  end

  always_comb begin
    mode_d     = mode_code(state_d);
    cursor_d   = cursor_q;
    blink_d    = blink_q;
    idle_d     = idle_q;
    parpadeo_d = parpadeo_q;
    inc_d      = 1'b0;
    dec_d      = 1'b0;
    if (state_d == StNormal) begin
      cursor_d   = '0;
      blink_d    = '0;
      idle_d     = '0;
      parpadeo_d = 1'b0;
    end else if (state_d != state_q) begin
      cursor_d   = CUR_MAX_HHMMSS;
      blink_d    = '0;
      idle_d     = '0;
      parpadeo_d = 1'b1;
    end else if (press != PressNone) begin
      blink_d    = '0;
      idle_d     = '0;
      parpadeo_d = 1'b1;
      unique case (press)
        PressLeft:  cursor_d = (cursor_q == cursor_max(state_q)) ? 2'd0 : cursor_q + 2'd1;
        PressRight: cursor_d = (cursor_q == 2'd0) ? cursor_max(state_q) : cursor_q - 2'd1;
        PressUp:    inc_d = 1'b1;
        PressDown:  dec_d = 1'b1;
        default:    ;
      endcase
    end else if (blink_q == BLINK_LAST) begin
      blink_d    = '0;
      parpadeo_d = ~parpadeo_q;
      if (idle_q != IDLE_LAST) idle_d = idle_q + 1'b1;
    end else begin
      blink_d = blink_q + 1'b1;
    end
  end

  assign cfg.config_mode     = mode_q;
  assign cfg.cursor_location = cursor_q;
  assign cfg.parpadeo        = parpadeo_q;
  assign cfg.inc_pulse       = inc_q;
  assign cfg.dec_pulse       = dec_q;

endmodule

// File: tb/tb_config_sequencer.sv
// Directed bench: a slow-blink instance for cursor/mode/strobe behaviour and a fast-blink
// instance for blink period and idle auto-exit; both see the same buttons and reset.
module tb_config_sequencer;

  localparam int BCFG = 0, BLEFT = 1, BRIGHT = 2, BUP = 3, BDOWN = 4;

  logic clk = 1'b0;
  logic reset;
  logic b_cfg, b_left, b_right, b_up, b_down;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cnt;

  always #5 clk = ~clk;

  config_sequencer_if if_f ();
  config_sequencer_if if_a ();

  assign if_f.btn_config = b_cfg;
  assign if_f.btn_left   = b_left;
  assign if_f.btn_right  = b_right;
  assign if_f.btn_up     = b_up;
  assign if_f.btn_down   = b_down;
  assign if_a.btn_config = b_cfg;
  assign if_a.btn_left   = b_left;
  assign if_a.btn_right  = b_right;
  assign if_a.btn_up     = b_up;
  assign if_a.btn_down   = b_down;

  config_sequencer #(
    .BLINK_CYCLES(64),
    .IDLE_HALVES (20)
  ) dut_f (
    .clk  (clk),
    .reset(reset),
    .cfg  (if_f)
  );

  config_sequencer #(
    .BLINK_CYCLES(4),
    .IDLE_HALVES (3)
  ) dut_a (
    .clk  (clk),
    .reset(reset),
    .cfg  (if_a)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_btn(input int which, input logic v);
    case (which)
      BCFG:    b_cfg   = v;
      BLEFT:   b_left  = v;
      BRIGHT:  b_right = v;
      BUP:     b_up    = v;
      default: b_down  = v;
    endcase
  endtask

  // Leaves the sample point just after the edge that registers the action.
  task automatic press(input int which);
    set_btn(which, 1'b1);
    tick(1);
    set_btn(which, 1'b0);
    tick(1);
  endtask

  task automatic check_f(input string tag, input int mode, input int cur, input int par);
    check({tag, ".mode"}, 32'(if_f.config_mode), mode);
    check({tag, ".cursor"}, 32'(if_f.cursor_location), cur);
    check({tag, ".parpadeo"}, 32'(if_f.parpadeo), par);
  endtask

  initial begin
    reset = 1'b1;
    b_cfg = 1'b1;
    b_left = 1'b0; b_right = 1'b0; b_up = 1'b0; b_down = 1'b0;

    // Reset with config held.
    tick(3);
    check_f("reset", 0, 0, 0);
    check("reset.inc", 32'(if_f.inc_pulse), 0);
    check("reset.dec", 32'(if_f.dec_pulse), 0);
    reset = 1'b0;
    tick(4);
    check("held_cfg.mode", 32'(if_f.config_mode), 0);
    b_cfg = 1'b0;
    tick(2);
    press(BCFG);
    check_f("enter_hora", 1, 2, 1);

    // Left wraps from max to 0.
    press(BLEFT);
    check("hora_left1", 32'(if_f.cursor_location), 0);
    press(BLEFT);
    check("hora_left2", 32'(if_f.cursor_location), 1);
    press(BLEFT);
    check("hora_left3", 32'(if_f.cursor_location), 2);

    // Fecha: right from 0 wraps to the weekday field.
    press(BCFG);
    check_f("enter_fecha", 2, 2, 1);
    press(BRIGHT);
    press(BRIGHT);
    check("fecha_right0", 32'(if_f.cursor_location), 0);
    press(BRIGHT);
    check("fecha_right_wrap", 32'(if_f.cursor_location), 3);

    // Timer: left beats up in the same cycle.
    press(BCFG);
    check_f("enter_timer", 4, 2, 1);
    press(BRIGHT);
    check("timer_right", 32'(if_f.cursor_location), 1);
    b_up = 1'b1; b_left = 1'b1;
    tick(1);
    b_up = 1'b0; b_left = 1'b0;
    tick(1);
    check("prio_left.cursor", 32'(if_f.cursor_location), 2);
    check("prio_left.inc", 32'(if_f.inc_pulse), 0);
    press(BUP);
    check("up.inc", 32'(if_f.inc_pulse), 1);
    check("up.dec", 32'(if_f.dec_pulse), 0);
    tick(1);
    check("up.inc_width", 32'(if_f.inc_pulse), 0);

    // Held down gives a single one-cycle strobe.
    cnt = 0;
    b_down = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick(1);
      if (if_f.dec_pulse === 1'b1) cnt++;
    end
    b_down = 1'b0;
    tick(1);
    check("held_down.count", 32'(cnt), 1);

    // Normal mode ignores edit keys.
    press(BCFG);
    check_f("enter_normal", 0, 0, 0);
    press(BUP);
    check("normal_up.inc", 32'(if_f.inc_pulse), 0);
    press(BLEFT);
    check("normal_left.cursor", 32'(if_f.cursor_location), 0);
    b_cfg = 1'b1; b_left = 1'b1;
    tick(1);
    b_cfg = 1'b0; b_left = 1'b0;
    tick(1);
    check_f("prio_cfg", 1, 2, 1);

    // Blink period on the fast instance.
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(1);
    press(BCFG);
    check("blink.enter_par", 32'(if_a.parpadeo), 1);
    tick(3);
    check("blink.p3", 32'(if_a.parpadeo), 1);
    tick(1);
    check("blink.p4", 32'(if_a.parpadeo), 0);
    tick(1);
    press(BLEFT);
    check("blink.press_par", 32'(if_a.parpadeo), 1);
    check("blink.press_cursor", 32'(if_a.cursor_location), 0);
    tick(3);
    check("blink.restart3", 32'(if_a.parpadeo), 1);
    tick(1);
    check("blink.restart4", 32'(if_a.parpadeo), 0);

    // Idle auto-exit after three toggles.
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(1);
    press(BCFG);
    press(BCFG);
    check("idle.enter_mode", 32'(if_a.config_mode), 2);
    tick(12);
    check("idle.before_mode", 32'(if_a.config_mode), 2);
    tick(1);
    check("idle.exit_mode", 32'(if_a.config_mode), 0);
    check("idle.exit_cursor", 32'(if_a.cursor_location), 0);
    check("idle.exit_par", 32'(if_a.parpadeo), 0);
    tick(4);
    check("idle.normal_par", 32'(if_a.parpadeo), 0);
    check("idle.normal_mode", 32'(if_a.config_mode), 0);

    // Reset mid-edit drops an up strobe in flight.
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(1);
    press(BCFG);
    press(BCFG);
    check("rst_edit.mode", 32'(if_f.config_mode), 2);
    b_up = 1'b1;
    tick(1);
    reset = 1'b1;
    tick(1);
    check_f("rst_edit", 0, 0, 0);
    check("rst_edit.inc", 32'(if_f.inc_pulse), 0);
    check("rst_edit.dec", 32'(if_f.dec_pulse), 0);
    reset = 1'b0;
    tick(1);
    check("rst_edit.inc_after", 32'(if_f.inc_pulse), 0);
    b_up = 1'b0;
    tick(2);
    check("rst_edit.inc_late", 32'(if_f.inc_pulse), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
